// File: rtl/operand_mux_arbiter_pkg.sv
// Shared encodings for the operand mux arbiter: output-register state and source ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_mux_arbiter_pkg;

   // Output register occupancy: EMPTY has nothing to present, FULL holds a valid word.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Requester identities, used for mux select, out_src and the round-robin pointer.
   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/sixtyFourBitMux.sv
// Two-way datapath mux selecting between requester A and requester B words.
// Latency: combinational, zero cycles.
// Backpressure: none; the select is owned by the arbiter.
module sixtyFourBitMux #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   // sel=0 passes A, sel=1 passes B; data is never altered.
   assign y = sel ? b : a;

endmodule

// File: rtl/operand_mux_arbiter.sv
// Arbitrates requesters A/B into one registered output word through sixtyFourBitMux.
// Latency: 1 cycle from accepting edge to out_valid; one transfer per cycle while out_ready holds.
// Backpressure: FULL with out_ready=0 freezes the output and drops both readies; a contention loser stays pending.
// Build option: define OPERAND_MUX_ARB_RR_EN for round-robin arbitration, otherwise A has fixed priority.
module operand_mux_arbiter
   import operand_mux_arbiter_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   output logic             mux_sel
);

   state_t           state;
   state_t           state_nxt;
   logic             grant_vld;
   logic             grant_sel;
   logic             sel_q;
   logic             can_accept;
   logic             xfer;
   logic [WIDTH-1:0] mux_y;

`ifdef OPERAND_MUX_ARB_RR_EN
   // Identity of the requester that completed the most recent transfer.
   logic             last_grant;
`endif

   // Grant: contention goes to the policy winner, a lone requester wins outright, idle keeps the last select.
   always_comb begin
      grant_vld = a_valid | b_valid;
      grant_sel = sel_q;
      if (a_valid && b_valid) begin
`ifdef OPERAND_MUX_ARB_RR_EN
         grant_sel = (last_grant == SRC_A) ? SRC_B : SRC_A;
`else
         grant_sel = SRC_A;
`endif
      end else if (a_valid) begin
         grant_sel = SRC_A;
      end else if (b_valid) begin
         grant_sel = SRC_B;
      end
   end

   // Handshake: readies need a granted valid requester, room in the output register and no reset.
   always_comb begin
      can_accept = (state == EMPTY) || out_ready;
      mux_sel    = rst ? SRC_A : grant_sel;
      a_ready    = !rst && can_accept && a_valid && (grant_sel == SRC_A);
      b_ready    = !rst && can_accept && b_valid && (grant_sel == SRC_B);
      xfer       = a_ready || b_ready;
   end

   // Output-register FSM next state and out_valid decode.
   always_comb begin
      state_nxt = state;
      out_valid = (state == FULL);
      case (state)
         EMPTY:   if (xfer) state_nxt = FULL;
         FULL:    if (out_ready && !xfer) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Output data/source register, loaded only on a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_src  <= SRC_A;
      end else if (xfer) begin
         out_data <= mux_y;
         out_src  <= mux_sel;
      end
   end

   // Remember the last granted select so the mux holds steady when nobody requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            sel_q <= SRC_A;
      else if (grant_vld) sel_q <= grant_sel;
   end

`ifdef OPERAND_MUX_ARB_RR_EN
   // Round-robin pointer; resets to B so A wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last_grant <= SRC_B;
      else if (xfer) last_grant <= grant_sel;
   end
`endif

   sixtyFourBitMux #(
      .WIDTH(WIDTH)
   ) u_mux (
      .a   (a_data),
      .b   (b_data),
      .sel (mux_sel),
      .y   (mux_y)
   );

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Self-checking bench for operand_mux_arbiter: directed scenarios plus randomized traffic against a model.
// Latency: checks the 1-cycle accept-to-output path.
// Backpressure: exercises out_ready stalls and contention losers holding their requests.
module tb_operand_mux_arbiter;

   logic        clk;
   logic        rst;
   logic        a_valid;
   logic [63:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [63:0] b_data;
   logic        b_ready;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_src;
   logic        mux_sel;

   int total;
   int bad;

   operand_mux_arbiter #(.WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .mux_sel   (mux_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 64'h11; b_data = 64'h22;
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++;
      if (out_data !== 64'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      total++;
      if (out_src !== 1'b0) begin bad++; $display("FAIL rst_out_src got=%b exp=0", out_src); end
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         bad++; $display("FAIL rst_readies got=%b%b exp=00", a_ready, b_ready);
      end
      total++;
      if (mux_sel !== 1'b0) begin bad++; $display("FAIL rst_mux_sel got=%b exp=0", mux_sel); end
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_a();
      a_valid = 1'b1; a_data = 64'hFFFF_FFFF_FFFF_FFFF; b_valid = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         bad++; $display("FAIL single_a_ready got=%b%b exp=10", a_ready, b_ready);
      end
      tick();
      a_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_FFFF_FFFF || out_src !== 1'b0) begin
         bad++; $display("FAIL single_a_out got v=%b d=%h s=%b exp v=1 d=ffffffffffffffff s=0",
                         out_valid, out_data, out_src);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL single_a_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_contention();
      logic exp_src;
      pulse_reset();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 64'h1; b_data = 64'h2; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef OPERAND_MUX_ARB_RR_EN
         exp_src = k[0];
`else
         exp_src = 1'b0;
`endif
         #1;
         total++;
         if (a_ready !== ~exp_src || b_ready !== exp_src) begin
            bad++; $display("FAIL contend_ready k=%0d got=%b%b exp=%b%b", k, a_ready, b_ready, ~exp_src, exp_src);
         end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== (exp_src ? 64'h2 : 64'h1)) begin
            bad++; $display("FAIL contend_out k=%0d got v=%b s=%b d=%h exp s=%b", k, out_valid, out_src, out_data, exp_src);
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      b_valid = 1'b1; b_data = 64'h5555; a_valid = 1'b0; out_ready = 1'b1;
      tick();
      b_valid = 1'b0; out_ready = 1'b0;
      #1;
      total++;
      if (mux_sel !== 1'b1) begin bad++; $display("FAIL stall_sel_hold got=%b exp=1", mux_sel); end
      a_valid = 1'b1; b_valid = 1'b1; a_data = 64'hAAAA; b_data = 64'h7777;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0 || out_valid !== 1'b1 ||
             out_data !== 64'h5555 || out_src !== 1'b1) begin
            bad++; $display("FAIL stall_hold k=%0d got r=%b%b v=%b d=%h s=%b exp r=00 v=1 d=5555 s=1",
                            k, a_ready, b_ready, out_valid, out_data, out_src);
         end
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_stream();
      b_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_valid = 1'b1; a_data = 64'(i);
         #1;
         total++;
         if (a_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, a_ready); end
         tick();
         total++;
         if (out_valid !== 1'b1 || out_data !== 64'(i)) begin
            bad++; $display("FAIL stream_out i=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 64'(i));
         end
      end
      a_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1; a_data = 64'hDEAD; b_valid = 1'b0; out_ready = 1'b1;
      tick();
      a_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 64'hDEAD) begin
         bad++; $display("FAIL midrst_pre got v=%b d=%h exp v=1 d=dead", out_valid, out_data);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || out_src !== 1'b0) begin
         bad++; $display("FAIL midrst_clear got v=%b d=%h s=%b exp v=0 d=0 s=0", out_valid, out_data, out_src);
      end
      a_valid = 1'b1; out_ready = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b0 || mux_sel !== 1'b0) begin
         bad++; $display("FAIL midrst_ready got r=%b sel=%b exp r=0 sel=0", a_ready, mux_sel);
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_xfer got=%b exp=0", out_valid); end
      rst = 1'b0; a_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic        pa, pb, m_valid, m_src, m_last, acc, win, exp_ar, exp_br;
      logic [63:0] da, db, m_data;
      pulse_reset();
      pa = 1'b0; pb = 1'b0; da = '0; db = '0;
      m_valid = 1'b0; m_data = '0; m_src = 1'b0;
      m_last = 1'b1;  // after reset B counts as last winner
      for (int c = 0; c < 400; c++) begin
         if (!pa && $urandom_range(2) == 0) begin pa = 1'b1; da = {$urandom, $urandom}; end
         if (!pb && $urandom_range(2) == 0) begin pb = 1'b1; db = {$urandom, $urandom}; end
         a_valid = pa; a_data = da; b_valid = pb; b_data = db;
         out_ready = ($urandom_range(3) != 0);
         #1;
         acc = !m_valid || out_ready;
         if (pa && pb) begin
`ifdef OPERAND_MUX_ARB_RR_EN
            win = m_last ? 1'b0 : 1'b1;
`else
            win = 1'b0;
`endif
         end else begin
            win = pb;
         end
         exp_ar = acc && pa && !win;
         exp_br = acc && pb && win;
         total++;
         if (a_ready !== exp_ar || b_ready !== exp_br) begin
            bad++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, a_ready, b_ready, exp_ar, exp_br);
         end
         tick();
         if (exp_ar || exp_br) begin
            m_valid = 1'b1; m_data = win ? db : da; m_src = win; m_last = win;
            if (win) pb = 1'b0;
            else     pa = 1'b0;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         total++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_src !== m_src))) begin
            bad++; $display("FAIL rnd_out c=%0d got v=%b d=%h s=%b exp v=%b d=%h s=%b",
                            c, out_valid, out_data, out_src, m_valid, m_data, m_src);
         end
      end
      a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
      tick();
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
      a_data = '0; b_data = '0;
      test_reset();
      test_single_a();
      test_contention();
      test_stall();
      test_stream();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_mux_arbiter.md
OPERAND_MUX_ARBITER -- requirements
Module: operand_mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, the data width of both requesters and the output.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have ports a_valid (input, 1), a_data (input, WIDTH) and a_ready (output, 1), forming requester A's valid/ready handshake.
REQ-005 The block SHALL have ports b_valid (input, 1), b_data (input, WIDTH) and b_ready (output, 1), forming requester B's valid/ready handshake.
REQ-006 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, WIDTH), forming the registered result handshake.
REQ-007 The block SHALL have port out_src, output, 1: source of out_data (0=A, 1=B).
REQ-008 The block SHALL have port mux_sel, output, 1: combinational select driven to the datapath mux (0=A, 1=B).

Function
REQ-009 The FSM SHALL have two states: EMPTY (output register invalid) and FULL (output register valid).
REQ-010 Accept condition: can_accept = (state==EMPTY) or out_ready.
REQ-011 Grant SHALL be combinational, given only to a valid requester; with neither valid there SHALL be no grant and mux_sel SHALL hold its last granted value.
REQ-012 a_ready/b_ready SHALL equal can_accept AND grant to that requester; at most one is high per cycle.
REQ-013 A transfer SHALL occur when the granted requester is valid and ready; on that edge out_data <= mux output, out_src <= mux_sel, and state <= FULL.
REQ-014 Latency SHALL be 1 cycle, from accepting edge to out_valid=1 with data.
REQ-015 In FULL with out_ready=1 and no transfer, the next state SHALL be EMPTY; with out_ready=1 and a transfer, state SHALL stay FULL and the output SHALL be replaced (1 transfer/cycle throughput).
REQ-016 In FULL with out_ready=0, out_data/out_src SHALL be stable and both readies SHALL be 0.
REQ-017 out_valid SHALL equal (state==FULL).
REQ-018 Both valid: the winner SHALL be decided per REQ-025/REQ-026; the loser SHALL see ready=0 and SHALL keep its request pending.
REQ-019 Requester data SHALL be passed unmodified; there is no arithmetic, and widths match WIDTH exactly.

Reset
REQ-020 Asserting rst SHALL immediately force state=EMPTY, out_valid=0, out_data=0, out_src=0, and the round-robin pointer to "last=B" (A wins next).
REQ-021 Reset mid-transfer SHALL discard any held output; no transfer SHALL complete on an edge where rst is high.
REQ-022 While rst is high, a_ready=b_ready=0 and mux_sel=0.

Configuration
REQ-023 The macro OPERAND_MUX_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 Priority pointer: a 1-bit register last_grant SHALL update on each transfer, and SHALL exist only when OPERAND_MUX_ARB_RR_EN is defined.
REQ-025 Defined: round-robin; on contention the requester not in last_grant wins.
REQ-026 Undefined: fixed priority; A always wins on contention.

Structure
REQ-027 A shared package SHALL hold the state encoding (EMPTY=0, FULL=1) and the source constants SRC_A=0, SRC_B=1.
REQ-028 The existing sixtyFourBitMux SHALL be instantiated as the single datapath sub-module, with inputs a_data/b_data, select mux_sel, and output feeding the out_data register.

Verification
REQ-029 Scenario: rst pulsed mid-FULL, holding out_data=0xDEAD -> out_valid=0 and out_data=0 immediately, before the next clk edge.
REQ-030 Scenario: a_valid=1, a_data=0xFFFFFFFFFFFFFFFF, out_ready=1, b_valid=0 -> a_ready=1; next cycle out_valid=1, out_data=all ones, out_src=0.
REQ-031 Scenario: both valid for 4 cycles, A=0x1, B=0x2, out_ready=1 -> RR defined: out_src sequence 0,1,0,1; RR undefined: 0,0,0,0.
REQ-032 Scenario: out_ready=0 after a transfer of b_data=0x5555 -> out_data stays 0x5555 with out_src=1 for 3 cycles, and a_ready=b_ready=0.
REQ-033 Scenario: a continuous stream of 8 A words 0..7 with out_ready=1 -> 8 consecutive out_valid cycles, data 0..7 in order, no bubbles.
